// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit for a word whose bits XOR to i_xor, under parity type i_typ.
  function automatic logic parity_bit(input logic i_xor, input logic i_typ);
    return (i_typ == PAR_ODD) ? ~i_xor : i_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter feeding the data bits of a frame, LSB first.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic                  i_count,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_lsb,
  output logic                  o_done
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CW-1:0]         r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
    end
  end

  // Counter runs only while in DATA and returns to zero as DATA is left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!i_count || o_done) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_lsb  = r_shreg[0];
  assign o_done = i_count && (r_count == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit;
// one bit per clock period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  uart_state_e r_state, w_next;
  logic        r_tx, r_busy;
  logic        r_par_en, r_par_bit;
  logic        w_load, w_shift, w_count, w_tx_next;
  logic        w_lsb, w_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_count(w_count),
    .i_data (p_data),
    .o_lsb  (w_lsb),
    .o_done (w_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_count = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_valid) begin
          w_next = START;
          w_load = 1'b1;
        end
      end
      START: begin
        w_next  = DATA;
        w_shift = 1'b1;
      end
      DATA: begin
        w_shift = 1'b1;
        w_count = 1'b1;
        if (w_done) begin
          w_next = r_par_en ? PARITY : STOP;
        end
      end
      PARITY:  w_next = STOP;
      STOP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The line is registered, so its next level is chosen from the state being entered.
  always_comb begin
    w_tx_next = STOP_BIT;
    case (w_next)
      START:   w_tx_next = START_BIT;
      DATA:    w_tx_next = w_lsb;
      PARITY:  w_tx_next = r_par_bit;
      default: w_tx_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx   <= STOP_BIT;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (w_next != IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= par_en;
      r_par_bit <= parity_bit(^p_data, par_typ);
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames
// checked against a bit-list model of the frame format.
module tb_uart_tx;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         tx_out;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line levels, one per cycle starting at the accepting edge.
  task automatic build_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             output logic bits[$]);
    int ones;
    bits = {};
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    bits.push_back(1'b1);
  endtask

  // Starts at a falling edge with the DUT idle; ends at a falling edge one
  // cycle into the following idle period, after checking that cycle.
  task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                           input bit noise, input bit hold, input int chg_at,
                           input string name);
    logic bits[$];
    build_frame(d, pe, pt, bits);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < bits.size(); k++) begin
      @(negedge clock);
      if (!hold) data_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        p_data  = W'($urandom);
        par_en  = 1'($urandom_range(0, 1));
        par_typ = 1'($urandom_range(0, 1));
      end
      if (k == chg_at) p_data = '1;
      check($sformatf("%s tx bit%0d", name, k), 32'(tx_out), 32'(bits[k]));
      check($sformatf("%s busy%0d", name, k), 32'(busy), 32'd1);
    end
    @(negedge clock);
    if (!hold) data_valid = 1'b0;
    check({name, " idle tx"}, 32'(tx_out), 32'd1);
    check({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rd;
    repeat (2) @(negedge clock);
    check("reset tx", 32'(tx_out), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle tx", 32'(tx_out), 32'd1);
      check("idle busy", 32'(busy), 32'd0);
    end

    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1, "a5_nopar");
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1, "a5_even");
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 3, "a5_odd_chg");
    run_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, -1, "zero_odd");
    run_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, -1, "ff_even_noise");

    for (int i = 0; i < 3; i++) run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, "b2b_3c");
    data_valid = 1'b0;
    @(negedge clock);
    check("b2b drop tx", 32'(tx_out), 32'd1);
    check("b2b drop busy", 32'(busy), 32'd0);

    // Abort during data bit 4, which is on the line from edge 5 to edge 6.
    p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    data_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("pre-abort tx bit4", 32'(tx_out), 32'(p_data[4]));
    reset = 1'b0;
    #1;
    check("abort tx", 32'(tx_out), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("abort hold tx", 32'(tx_out), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("post-abort idle tx", 32'(tx_out), 32'd1);
    check("post-abort idle busy", 32'(busy), 32'd0);
    run_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, -1, "post_abort");

    for (int i = 0; i < 20; i++) begin
      rd = W'($urandom);
      run_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b1, 1'b0, -1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
